// File: rtl/hsv_core_pkg.sv
// Shared types and defaults for the core memory stage.
package hsv_core_pkg;

    localparam int unsigned PENDING_FIFO_DEPTH_DEFAULT = 8;
    localparam int unsigned COUNTER_WIDTH_DEFAULT = $clog2(PENDING_FIFO_DEPTH_DEFAULT) + 2;

    typedef logic signed [COUNTER_WIDTH_DEFAULT-1:0] mem_counter;
    typedef logic [31:0] word;

endpackage

// File: rtl/hsv_core_mem_pending_if.sv
// Issue/response bookkeeping bundle between the dmem request logic and the pending tracker.
interface hsv_core_mem_pending_if
    import hsv_core_pkg::*;
#(
    parameter int unsigned DEPTH = PENDING_FIFO_DEPTH_DEFAULT
);

    logic                  pending_reads_up;
    word                   pending_read_address;
    logic                  pending_writes_up;
    word                   pending_write_address;
    logic                  read_done;
    logic                  write_done;
    logic                  pending_reads_stall;
    logic                  pending_writes_stall;
    word  [DEPTH-1:0]      pending_reads_peek;
    logic [DEPTH-1:0]      pending_reads_peek_valid;
    word  [DEPTH-1:0]      pending_writes_peek;
    logic [DEPTH-1:0]      pending_writes_peek_valid;

    modport master (
        output pending_reads_up, pending_read_address, pending_writes_up, pending_write_address,
        output read_done, write_done,
        input  pending_reads_stall, pending_writes_stall,
        input  pending_reads_peek, pending_reads_peek_valid,
        input  pending_writes_peek, pending_writes_peek_valid
    );

    modport slave (
        input  pending_reads_up, pending_read_address, pending_writes_up, pending_write_address,
        input  read_done, write_done,
        output pending_reads_stall, pending_writes_stall,
        output pending_reads_peek, pending_reads_peek_valid,
        output pending_writes_peek, pending_writes_peek_valid
    );

endinterface

// File: rtl/hsv_core_mem_pending_fifo.sv
// Circular address FIFO with per-slot peek, occupancy vector, count, full flag and
// an underflow pulse raised when a pop arrives while empty.
module hsv_core_mem_pending_fifo
    import hsv_core_pkg::*;
#(
    parameter int unsigned Depth      = PENDING_FIFO_DEPTH_DEFAULT,
    parameter int unsigned CountWidth = $clog2(Depth) + 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  push_i,
    input  word                   push_addr_i,
    input  logic                  pop_i,
    output word  [Depth-1:0]      peek_o,
    output logic [Depth-1:0]      peek_valid_o,
    output logic [CountWidth-1:0] count_o,
    output logic                  full_o,
    output logic                  underflow_o
);

    localparam int unsigned PtrWidth = $clog2(Depth);

    logic [PtrWidth-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PtrWidth-1:0]   rd_ptr_q, rd_ptr_d;
    logic [Depth-1:0]      valid_q, valid_d;
    logic [CountWidth-1:0] count_q, count_d;
    word  [Depth-1:0]      addr_q;
    logic                  full, empty, push_ok, pop_ok;

    always_comb begin
        full    = (count_q == CountWidth'(Depth));
        empty   = (count_q == '0);
        pop_ok  = pop_i & ~empty;
        // A push into a full FIFO is accepted only when a pop frees the slot in the same cycle.
        push_ok = push_i & (~full | pop_ok);

        valid_d  = valid_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (pop_ok) begin
            valid_d[rd_ptr_q] = 1'b0;
            rd_ptr_d          = rd_ptr_q + PtrWidth'(1);
        end
        if (push_ok) begin
            valid_d[wr_ptr_q] = 1'b1;
            wr_ptr_d          = wr_ptr_q + PtrWidth'(1);
        end
        if (push_ok && !pop_ok) begin
            count_d = count_q + CountWidth'(1);
        end else if (pop_ok && !push_ok) begin
            count_d = count_q - CountWidth'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            valid_q  <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            valid_q  <= valid_d;
            count_q  <= count_d;
        end
    end

    // Address storage is qualified by valid_q, so it needs no reset.
    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            addr_q[wr_ptr_q] <= push_addr_i;
        end
    end

    assign peek_o       = addr_q;
    assign peek_valid_o = valid_q;
    assign count_o      = count_q;
    assign full_o       = full;
    assign underflow_o  = pop_i & empty;

endmodule

// File: rtl/hsv_core_mem_pending.sv
// Outstanding dmem transaction tracker: read/write pending FIFOs, write credit balance,
// fence readiness and flush quiescence handshake.
module hsv_core_mem_pending
    import hsv_core_pkg::*;
#(
    parameter int unsigned PENDING_FIFO_DEPTH = PENDING_FIFO_DEPTH_DEFAULT,
    parameter int unsigned COUNTER_WIDTH      = $clog2(PENDING_FIFO_DEPTH) + 2
) (
    input  logic                            clk_core,
    input  logic                            rst_core,
    input  logic                            flush,
    input  logic                            flush_req,
    output logic                            flush_ack,
    input  logic                            commit_write,
    input  logic                            write_balance_down,
    output logic        [COUNTER_WIDTH-1:0] pending_reads,
    output logic        [COUNTER_WIDTH-1:0] pending_writes,
    output logic signed [COUNTER_WIDTH-1:0] write_balance,
    output logic                            fence_ready,
    output logic                            protocol_error,
    hsv_core_mem_pending_if.slave           mem
);

    logic                            read_underflow, write_underflow;
    logic signed [COUNTER_WIDTH-1:0] write_balance_q, write_balance_d;
    logic                            flush_ack_q, flush_ack_d;
    logic                            protocol_error_q, protocol_error_d;
    // Flush leaves all bookkeeping intact: in-flight responses and owed writes still drain.
    logic                            flush_unused;

    assign flush_unused = flush;

    hsv_core_mem_pending_fifo #(
        .Depth      (PENDING_FIFO_DEPTH),
        .CountWidth (COUNTER_WIDTH)
    ) u_read_fifo (
        .clk_i        (clk_core),
        .rst_i        (rst_core),
        .push_i       (mem.pending_reads_up),
        .push_addr_i  (mem.pending_read_address),
        .pop_i        (mem.read_done),
        .peek_o       (mem.pending_reads_peek),
        .peek_valid_o (mem.pending_reads_peek_valid),
        .count_o      (pending_reads),
        .full_o       (mem.pending_reads_stall),
        .underflow_o  (read_underflow)
    );

    hsv_core_mem_pending_fifo #(
        .Depth      (PENDING_FIFO_DEPTH),
        .CountWidth (COUNTER_WIDTH)
    ) u_write_fifo (
        .clk_i        (clk_core),
        .rst_i        (rst_core),
        .push_i       (mem.pending_writes_up),
        .push_addr_i  (mem.pending_write_address),
        .pop_i        (mem.write_done),
        .peek_o       (mem.pending_writes_peek),
        .peek_valid_o (mem.pending_writes_peek_valid),
        .count_o      (pending_writes),
        .full_o       (mem.pending_writes_stall),
        .underflow_o  (write_underflow)
    );

    always_comb begin
        write_balance_d = write_balance_q;
        if (commit_write && !write_balance_down) begin
            write_balance_d = write_balance_q + COUNTER_WIDTH'(1);
        end else if (write_balance_down && !commit_write) begin
            write_balance_d = write_balance_q - COUNTER_WIDTH'(1);
        end

        flush_ack_d = flush_req & (pending_reads == '0) & (pending_writes == '0) &
                      (write_balance_q[COUNTER_WIDTH-1] | (write_balance_q == '0));

        protocol_error_d = protocol_error_q | read_underflow | write_underflow;
    end

    always_ff @(posedge clk_core or posedge rst_core) begin
        if (rst_core) begin
            write_balance_q  <= '0;
            flush_ack_q      <= 1'b0;
            protocol_error_q <= 1'b0;
        end else begin
            write_balance_q  <= write_balance_d;
            flush_ack_q      <= flush_ack_d;
            protocol_error_q <= protocol_error_d;
        end
    end

    assign write_balance  = write_balance_q;
    assign flush_ack      = flush_ack_q;
    assign protocol_error = protocol_error_q;
    assign fence_ready    = (pending_reads == '0) & (pending_writes == '0);

endmodule

// File: tb/tb_hsv_core_mem_pending.sv
// Bench for hsv_core_mem_pending: directed scenarios with literal expectations plus a
// randomized phase, all checked every cycle against a queue-based reference model.
module tb_hsv_core_mem_pending;
    import hsv_core_pkg::*;

    localparam int D  = 8;
    localparam int CW = $clog2(D) + 2;

    logic                 clk = 1'b0;
    logic                 rst_core = 1'b1;
    logic                 flush = 1'b0;
    logic                 flush_req = 1'b0;
    logic                 commit_write = 1'b0;
    logic                 write_balance_down = 1'b0;
    logic                 flush_ack;
    logic        [CW-1:0] pending_reads, pending_writes;
    mem_counter           write_balance;
    logic                 fence_ready, protocol_error;

    int n_tests = 0;
    int n_fail  = 0;

    hsv_core_mem_pending_if #(.DEPTH(D)) mem_if ();

    hsv_core_mem_pending #(.PENDING_FIFO_DEPTH(D)) dut (
        .clk_core           (clk),
        .rst_core           (rst_core),
        .flush              (flush),
        .flush_req          (flush_req),
        .flush_ack          (flush_ack),
        .commit_write       (commit_write),
        .write_balance_down (write_balance_down),
        .pending_reads      (pending_reads),
        .pending_writes     (pending_writes),
        .write_balance      (write_balance),
        .fence_ready        (fence_ready),
        .protocol_error     (protocol_error),
        .mem                (mem_if)
    );

    always #5 clk = ~clk;

    // Reference model: outstanding transactions as ordered address lists.
    word m_rq[$];
    word m_wq[$];
    int  m_bal  = 0;
    bit  m_perr = 1'b0;
    bit  m_fack = 1'b0;

    always @(posedge clk or posedge rst_core) begin
        bit fa, rpop, wpop, rpush, wpush;
        if (rst_core) begin
            m_rq.delete();
            m_wq.delete();
            m_bal  = 0;
            m_perr = 1'b0;
            m_fack = 1'b0;
        end else begin
            fa    = flush_req && m_rq.size() == 0 && m_wq.size() == 0 && m_bal <= 0;
            rpop  = mem_if.read_done && m_rq.size() > 0;
            wpop  = mem_if.write_done && m_wq.size() > 0;
            rpush = mem_if.pending_reads_up && (m_rq.size() < D || rpop);
            wpush = mem_if.pending_writes_up && (m_wq.size() < D || wpop);
            if (mem_if.read_done && m_rq.size() == 0) m_perr = 1'b1;
            if (mem_if.write_done && m_wq.size() == 0) m_perr = 1'b1;
            if (rpop) void'(m_rq.pop_front());
            if (wpop) void'(m_wq.pop_front());
            if (rpush) m_rq.push_back(mem_if.pending_read_address);
            if (wpush) m_wq.push_back(mem_if.pending_write_address);
            m_bal  = m_bal + int'(commit_write) - int'(write_balance_down);
            m_fack = fa;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Slot order is irrelevant, so compare the occupied peek slots as a multiset.
    function automatic bit peek_match(input word [D-1:0] pk, input logic [D-1:0] v,
                                      input word q[$]);
        word a[$];
        word b[$];
        b = q;
        for (int i = 0; i < D; i++) if (v[i]) a.push_back(pk[i]);
        if (a.size() != b.size()) return 1'b0;
        a.sort();
        b.sort();
        for (int i = 0; i < a.size(); i++) if (a[i] != b[i]) return 1'b0;
        return 1'b1;
    endfunction

    always @(posedge clk) begin
        #2;
        if (!rst_core) begin
            check("m_pending_reads", int'(pending_reads), m_rq.size());
            check("m_pending_writes", int'(pending_writes), m_wq.size());
            check("m_reads_stall", int'(mem_if.pending_reads_stall), int'(m_rq.size() == D));
            check("m_writes_stall", int'(mem_if.pending_writes_stall), int'(m_wq.size() == D));
            check("m_write_balance", int'(write_balance), m_bal);
            check("m_fence_ready", int'(fence_ready),
                  int'(m_rq.size() == 0 && m_wq.size() == 0));
            check("m_flush_ack", int'(flush_ack), int'(m_fack));
            check("m_protocol_error", int'(protocol_error), int'(m_perr));
            check("m_reads_peek", int'(peek_match(mem_if.pending_reads_peek,
                  mem_if.pending_reads_peek_valid, m_rq)), 1);
            check("m_writes_peek", int'(peek_match(mem_if.pending_writes_peek,
                  mem_if.pending_writes_peek_valid, m_wq)), 1);
        end
    end

    task automatic idle();
        mem_if.pending_reads_up   = 1'b0;
        mem_if.pending_writes_up  = 1'b0;
        mem_if.read_done          = 1'b0;
        mem_if.write_done         = 1'b0;
        commit_write              = 1'b0;
        write_balance_down        = 1'b0;
        flush                     = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        mem_if.pending_read_address  = '0;
        mem_if.pending_write_address = '0;
        idle();
        tick();
        tick();
        check("rst_pending_reads", int'(pending_reads), 0);
        check("rst_write_balance", int'(write_balance), 0);
        check("rst_fence_ready", int'(fence_ready), 1);
        check("rst_read_valid", int'(mem_if.pending_reads_peek_valid), 0);
        rst_core = 1'b0;
        tick();

        // Three reads then three responses.
        for (int i = 0; i < 3; i++) begin
            mem_if.pending_reads_up     = 1'b1;
            mem_if.pending_read_address = 32'h100 + 32'(4 * i);
            tick();
            check("t1_reads_up", int'(pending_reads), i + 1);
        end
        check("t1_peak_valid", $countones(mem_if.pending_reads_peek_valid), 3);
        check("t1_fence_busy", int'(fence_ready), 0);
        idle();
        mem_if.read_done = 1'b1;
        for (int i = 2; i >= 0; i--) begin
            tick();
            check("t1_reads_down", int'(pending_reads), i);
        end
        check("t1_fence_back", int'(fence_ready), 1);
        idle();

        // Fill the write FIFO, then push+pop at full, then lone pop.
        mem_if.pending_writes_up = 1'b1;
        for (int i = 0; i < D; i++) begin
            mem_if.pending_write_address = 32'h200 + 32'(4 * i);
            tick();
        end
        check("t2_full_count", int'(pending_writes), 8);
        check("t2_full_stall", int'(mem_if.pending_writes_stall), 1);
        mem_if.pending_write_address = 32'h300;
        mem_if.write_done = 1'b1;
        tick();
        check("t2_pushpop_count", int'(pending_writes), 8);
        check("t2_pushpop_stall", int'(mem_if.pending_writes_stall), 1);
        mem_if.pending_writes_up = 1'b0;
        tick();
        check("t2_pop_count", int'(pending_writes), 7);
        check("t2_pop_stall", int'(mem_if.pending_writes_stall), 0);
        repeat (7) tick();
        check("t2_drained", int'(pending_writes), 0);
        idle();

        // Balance sequence 0, -1, -2, -1, -1.
        write_balance_down = 1'b1;
        tick();
        check("t3_bal_m1", int'(write_balance), -1);
        tick();
        check("t3_bal_m2", int'(write_balance), -2);
        write_balance_down = 1'b0;
        commit_write = 1'b1;
        tick();
        check("t3_bal_commit", int'(write_balance), -1);
        write_balance_down = 1'b1;
        tick();
        check("t3_bal_both", int'(write_balance), -1);
        write_balance_down = 1'b0;
        tick();
        tick();
        check("t3_bal_p1", int'(write_balance), 1);
        idle();

        // Flush handshake with one read, one write and a positive balance outstanding.
        mem_if.pending_reads_up  = 1'b1;
        mem_if.pending_writes_up = 1'b1;
        tick();
        idle();
        flush_req = 1'b1;
        flush     = 1'b1;
        tick();
        flush = 1'b0;
        check("t4_ack_busy0", int'(flush_ack), 0);
        tick();
        check("t4_ack_busy1", int'(flush_ack), 0);
        mem_if.read_done   = 1'b1;
        mem_if.write_done  = 1'b1;
        write_balance_down = 1'b1;
        tick();
        idle();
        check("t4_ack_late", int'(flush_ack), 0);
        tick();
        check("t4_ack_set", int'(flush_ack), 1);
        flush_req = 1'b0;
        tick();
        check("t4_ack_drop", int'(flush_ack), 0);

        // Pop on empty, sticky error, then asynchronous reset mid-operation.
        mem_if.write_done = 1'b1;
        tick();
        idle();
        check("t5_perr_set", int'(protocol_error), 1);
        check("t5_writes_same", int'(pending_writes), 0);
        tick();
        check("t5_perr_sticky", int'(protocol_error), 1);
        mem_if.pending_reads_up = 1'b1;
        repeat (3) tick();
        idle();
        check("t5_three_reads", int'(pending_reads), 3);
        rst_core = 1'b1;
        #1;
        check("t5_async_reads", int'(pending_reads), 0);
        check("t5_async_valid", int'(mem_if.pending_reads_peek_valid), 0);
        check("t5_async_perr", int'(protocol_error), 0);
        tick();
        rst_core = 1'b0;
        tick();

        // Randomized traffic; inputs respect the legal envelope from the model state.
        for (int c = 0; c < 3000; c++) begin
            idle();
            mem_if.read_done  = (m_rq.size() > 0) && ($urandom_range(2) == 0);
            mem_if.write_done = (m_wq.size() > 0) && ($urandom_range(2) == 0);
            mem_if.pending_reads_up  = ($urandom_range(1) == 1) &&
                                       (m_rq.size() < D || mem_if.read_done);
            mem_if.pending_writes_up = ($urandom_range(1) == 1) &&
                                       (m_wq.size() < D || mem_if.write_done);
            mem_if.pending_read_address  = {$urandom_range(32'h3fff_ffff), 2'b00};
            mem_if.pending_write_address = {$urandom_range(32'h3fff_ffff), 2'b00};
            commit_write       = ($urandom_range(2) == 0) && (m_bal < D - 1);
            write_balance_down = ($urandom_range(2) == 0) && (m_bal > -(D - 1));
            flush = ($urandom_range(15) == 0);
            if ($urandom_range(7) == 0) flush_req = ~flush_req;
            tick();
        end
        idle();
        flush_req = 1'b0;
        tick();
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/hsv_core_mem_pending.md
Name: hsv_core_mem_pending

Overview:
- Bookkeeping/scheduling controller for the memory request stage.
- Tracks dmem transactions issued but not yet answered: reads on AR→R, writes on AW/W→B.
- Owns the pending_reads, pending_writes and write_balance counters, the per-address peek FIFOs used for hazard checks, and fence readiness.
- Sequences flush: signals when the memory unit has drained enough for the core to proceed.

Parameters:
- PENDING_FIFO_DEPTH, 8: outstanding entries per direction; must be a power of two, ≥2.
- COUNTER_WIDTH, $clog2(PENDING_FIFO_DEPTH)+2: signed width of mem_counter.

Ports:
- clk_core  in  1  core clock.
- rst_core  in  1  asynchronous, active-high reset.
- flush  in  1  pipeline flush pulse.
- flush_req  in  1  flush requested; the memory unit must quiesce.
- flush_ack  out  1  registered; memory unit quiescent under flush_req.
- pending_reads_up  in  1  read issued on AR this cycle.
- pending_read_address  in  32  word-aligned read address.
- pending_writes_up  in  1  write issued on AW/W this cycle.
- pending_write_address  in  32  word-aligned write address.
- read_done  in  1  R beat accepted (one per read).
- write_done  in  1  B response accepted (one per write).
- commit_write  in  1  commit retired one memory write.
- write_balance_down  in  1  a memory write consumed one balance credit.
- pending_reads_stall  out  1  read FIFO full.
- pending_writes_stall  out  1  write FIFO full.
- pending_reads  out  COUNTER_WIDTH  outstanding read count.
- pending_writes  out  COUNTER_WIDTH  outstanding write count.
- write_balance  out  COUNTER_WIDTH  signed: commits minus issued memory writes.
- fence_ready  out  1  no reads or writes outstanding.
- pending_reads_peek  out  32×DEPTH  read FIFO slot addresses.
- pending_reads_peek_valid  out  DEPTH  per-slot occupancy.
- pending_writes_peek  out  32×DEPTH  write FIFO slot addresses.
- pending_writes_peek_valid  out  DEPTH  per-slot occupancy.
- protocol_error  out  1  sticky: done received while the matching FIFO was empty.

Behaviour:
- Reset, asynchronous on rst_core high:
  - all counters 0, pointers 0, valid vectors 0;
  - flush_ack 0, protocol_error 0;
  - peek address storage is not reset.
- FIFOs, one per direction, circular:
  - push on *_up writes the address at the write pointer and sets that slot's valid bit;
  - pop on *_done clears the valid bit at the read pointer.
  - Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
  - Peek is by physical slot; slot order is irrelevant to consumers.
- Counts:
  - pending_reads/pending_writes equal the popcount of their valid vector, kept as registered counters.
  - Push and pop in the same cycle leave the count unchanged, with both operations performed.
- Stalls:
  - *_stall = (count == DEPTH), combinational from the registered count.
  - A same-cycle pop does not clear the stall.
  - A push while full is ignored; the bench asserts this never happens.
- Pop while empty: ignored, and protocol_error sets and holds until reset.
- write_balance:
  - +1 on commit_write, −1 on write_balance_down; both in one cycle leaves it unchanged.
  - Signed two's complement and may go negative; it never saturates within the legal range ±DEPTH.
- fence_ready = (pending_reads == 0) & (pending_writes == 0), combinational.
- Flush:
  - flush does not clear FIFOs, counters or write_balance. AXI responses for issued transactions must still be drained, and committed writes still owe issue.
  - flush_ack registers (flush_req & pending_reads==0 & pending_writes==0 & write_balance<=0), so it is 1 cycle late.
  - flush_ack deasserts the cycle after flush_req drops.
- Latency: all outputs except stalls and fence_ready reflect an event the cycle after it occurs.
- Reset mid-operation discards all outstanding state; the dmem interface is reset by the same signal.

Decomposition:
- hsv_core_pkg holds:
  - mem_counter (logic signed [COUNTER_WIDTH-1:0]);
  - word;
  - the default PENDING_FIFO_DEPTH constant.
- One sub-module, hsv_core_mem_pending_fifo: circular address FIFO with peek array, valid vector, count, full flag and an underflow pulse. It is instantiated twice (read, write).
- The top level adds write_balance, fence_ready, flush_ack and protocol_error.

Test Plan:
1. Issue reads to 0x100, 0x104, 0x108 on consecutive cycles, then three read_done → pending_reads steps 1,2,3,2,1,0; peek_valid shows 3 bits set at peak; fence_ready returns to 1 the cycle after the last done.
2. Push 8 writes with no done → pending_writes_stall=1 with count 8. Then push+pop in the same cycle → count stays 8 and the stall stays 1. Then a lone pop → count 7, stall 0.
3. write_balance_down twice, then commit_write once, then both together → write_balance 0, −1, −2, −1, −1.
4. flush_req with 1 read outstanding and balance +1 → flush_ack stays 0. After read_done and one write_balance_down plus write_done → flush_ack=1 one cycle later. Drop flush_req → flush_ack 0 the next cycle.
5. write_done with the write FIFO empty → protocol_error=1 and sticky; counts unchanged. Assert rst_core mid-operation with 3 entries → all counts, valid vectors and protocol_error are 0 immediately (asynchronous).
